// File: rtl/tile_stream_buffer.sv
// tile_stream_buffer: fetches an N x K column-major tile over a req/rsp memory port
// and streams its columns PASSES times, overlapping the stream with the load.
module tile_stream_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int P          = 2,
    parameter int MAX_LEN    = 4096,
    parameter int ADDR_BITS  = 64,
    parameter int LEN_BITS   = $clog2(MAX_LEN + 1),
    parameter int PASS_BITS  = $clog2(MAX_LEN / N + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ADDR_BITS-1:0]         cmd_addr,
    input  logic [LEN_BITS-1:0]          cmd_len,
    input  logic [PASS_BITS-1:0]         cmd_passes,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [ADDR_BITS-1:0]         mem_req_addr,
    input  logic                         mem_rsp_valid,
    input  logic [P-1:0][DATA_WIDTH-1:0] mem_rsp_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N-1:0][DATA_WIDTH-1:0] out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);
    localparam int BW    = LEN_BITS + $clog2(N) + 1;
    localparam int EW    = BW + $clog2(P) + 1;
    localparam int DEPTH = MAX_LEN * N;
    localparam int IW    = $clog2(DEPTH);

    if (N % P != 0) begin : g_bad_p
        $error("tile_stream_buffer: P must divide N");
    end

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, FINISH} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [ADDR_BITS-1:0]         r_base;
    logic [LEN_BITS-1:0]          r_len;
    logic [LEN_BITS-1:0]          r_col;
    logic [PASS_BITS-1:0]         r_passes;
    logic [PASS_BITS-1:0]         r_pass;
    logic [BW-1:0]                r_beats;
    logic [BW-1:0]                r_req_cnt;
    logic [BW-1:0]                r_rsp_cnt;
    logic                         r_out_valid;
    logic                         r_out_last;
    logic [N-1:0][DATA_WIDTH-1:0] r_out_data;
    logic [DATA_WIDTH-1:0]        r_buf [DEPTH];

    logic                         w_accept;
    logic                         w_empty_cmd;
    logic                         w_req_fire;
    logic                         w_rsp_take;
    logic                         w_streaming;
    logic                         w_more;
    logic                         w_avail;
    logic                         w_load;
    logic                         w_last_col;
    logic                         w_final_hs;
    logic [EW-1:0]                w_elems_rx;
    logic [EW-1:0]                w_col_end;
    logic [IW-1:0]                w_wr_base;
    logic [IW-1:0]                w_rd_base;
    logic [N-1:0][DATA_WIDTH-1:0] w_col_data;

    assign w_accept    = cmd_valid && (r_state == IDLE);
    assign w_empty_cmd = (cmd_len == '0) || (cmd_passes == '0);
    assign w_req_fire  = mem_req_valid && mem_req_ready;
    assign w_rsp_take  = mem_rsp_valid && (r_state == LOAD) && (r_rsp_cnt < r_beats);
    assign w_streaming = (r_state == LOAD) || (r_state == STREAM);

    // r_col/r_pass point at the next column to be placed in the output register,
    // so the pass count runs one column ahead of the processor's handshakes.
    assign w_more      = r_pass < r_passes;
    assign w_elems_rx  = EW'(r_rsp_cnt) * EW'(P);
    assign w_col_end   = (EW'(r_col) + EW'(1)) * EW'(N);
    assign w_avail     = (r_pass != '0) || (w_elems_rx >= w_col_end);
    assign w_load      = w_streaming && w_more && w_avail && (!r_out_valid || out_ready);
    assign w_last_col  = (r_col == r_len - LEN_BITS'(1));
    assign w_final_hs  = w_streaming && r_out_valid && out_ready && r_out_last && !w_more;

    assign mem_req_addr = r_base + ADDR_BITS'(r_req_cnt) * ADDR_BITS'(P);
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        cmd_ready     = 1'b0;
        mem_req_valid = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_state_nxt = w_empty_cmd ? FINISH : LOAD;
                end
            end
            LOAD: begin
                mem_req_valid = (r_req_cnt < r_beats);
                if (r_rsp_cnt == r_beats) begin
                    w_state_nxt = STREAM;
                end
                if (w_final_hs) begin
                    w_state_nxt = FINISH;
                end
            end
            STREAM: begin
                if (w_final_hs) begin
                    w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base      <= '0;
            r_len       <= '0;
            r_passes    <= '0;
            r_beats     <= '0;
            r_req_cnt   <= '0;
            r_rsp_cnt   <= '0;
            r_col       <= '0;
            r_pass      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_accept) begin
                r_base    <= cmd_addr;
                r_len     <= cmd_len;
                r_passes  <= cmd_passes;
                r_beats   <= (BW'(cmd_len) * BW'(N)) / BW'(P);
                r_req_cnt <= '0;
                r_rsp_cnt <= '0;
                r_col     <= '0;
                r_pass    <= '0;
            end
            if (w_req_fire) begin
                r_req_cnt <= r_req_cnt + BW'(1);
            end
            if (w_rsp_take) begin
                r_rsp_cnt <= r_rsp_cnt + BW'(1);
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_col_data;
                r_out_last  <= w_last_col;
                if (w_last_col) begin
                    r_col  <= '0;
                    r_pass <= r_pass + PASS_BITS'(1);
                end else begin
                    r_col <= r_col + LEN_BITS'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    // Tile storage: beat j fills slots j*P.., column k is read from slots k*N..
    assign w_wr_base = IW'(r_rsp_cnt) * IW'(P);
    assign w_rd_base = IW'(r_col) * IW'(N);

    always_ff @(posedge clk) begin
        if (w_rsp_take) begin
            for (int i = 0; i < P; i++) begin
                r_buf[w_wr_base + IW'(i)] <= mem_rsp_data[i];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < N; r++) begin
            w_col_data[r] = r_buf[w_rd_base + IW'(r)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_accept) begin
            assert (cmd_len <= LEN_BITS'(MAX_LEN))
            else $error("tile_stream_buffer: cmd_len exceeds MAX_LEN");
        end
    end

endmodule

// File: tb/tb_tile_stream_buffer.sv
// Bench for tile_stream_buffer: drives tiles against a memory model whose
// element at address a is a[7:0], and checks requests and columns against the tile rules.
module tb_tile_stream_buffer;
    localparam int DW  = 8;
    localparam int N   = 4;
    localparam int P   = 2;
    localparam int ML  = 4096;
    localparam int AB  = 64;
    localparam int LB  = $clog2(ML + 1);
    localparam int PB  = $clog2(ML / N + 1);

    typedef struct {
        int          due;
        logic [63:0] a;
    } rsp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [AB-1:0]        cmd_addr = '0;
    logic [LB-1:0]        cmd_len = '0;
    logic [PB-1:0]        cmd_passes = '0;
    logic                 mem_req_valid;
    logic                 mem_req_ready = 1'b0;
    logic [AB-1:0]        mem_req_addr;
    logic                 mem_rsp_valid = 1'b0;
    logic [P-1:0][DW-1:0] mem_rsp_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [N-1:0][DW-1:0] out_data;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tile_stream_buffer #(
        .DATA_WIDTH(DW), .N(N), .P(P), .MAX_LEN(ML), .ADDR_BITS(AB),
        .LEN_BITS(LB), .PASS_BITS(PB)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_passes(cmd_passes),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return a[7:0];
    endfunction

    task automatic check_cleared(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
    endtask

    // omode: 0 out_ready high, 1 toggling, 2 random.
    // qmode: 0 mem_req_ready high, 1 low for cycles 3..7, 2 random.
    // abort_at != 0: assert reset asynchronously in that cycle and return.
    task automatic run_tile(input logic [63:0] addr, input int k, input int passes, input int dly,
                            input int omode, input int qmode, input int abort_at);
        rsp_t        rq[$];
        int          exp_reqs;
        int          nreq = 0, ncol = 0, ndone = 0, done_t = -1, landed = 0, t = 0, pcol;
        int          limit;
        logic        prev_rsp = 1'b0, prev_ostall = 1'b0, prev_qstall = 1'b0, prev_olast = 1'b0;
        logic [63:0] prev_qaddr = '0;
        logic [N*DW-1:0] prev_odata = '0;
        logic [N*DW-1:0] exp_d;

        exp_reqs = (k == 0 || passes == 0) ? 0 : k * N / P;
        limit    = 300 + 8 * (k * passes + exp_reqs);

        @(negedge clk);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid  = 1'b1;
        cmd_addr   = addr;
        cmd_len    = LB'(k);
        cmd_passes = PB'(passes);

        while (t < limit) begin
            @(negedge clk);
            t++;
            if (prev_rsp) landed++;
            cmd_valid  = (busy && !done) ? 1'($urandom) : 1'b0;
            cmd_addr   = {$urandom, $urandom};
            cmd_len    = LB'($urandom_range(1, 8));
            cmd_passes = PB'($urandom_range(1, 3));
            case (omode)
                0: out_ready = 1'b1;
                1: out_ready = 1'(t & 1);
                default: out_ready = 1'($urandom);
            endcase
            case (qmode)
                0: mem_req_ready = 1'b1;
                1: mem_req_ready = !(t >= 3 && t < 8);
                default: mem_req_ready = 1'($urandom);
            endcase
            if (rq.size() > 0 && rq[0].due <= t) begin
                mem_rsp_valid = 1'b1;
                for (int i = 0; i < P; i++) mem_rsp_data[i] = mem_byte(rq[0].a + 64'(i));
                void'(rq.pop_front());
                prev_rsp = 1'b1;
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = P*DW'($urandom);
                prev_rsp      = 1'b0;
            end
            #1;
            if (abort_at != 0 && t == abort_at) begin
                reset = 1'b0;
                #1;
                check_cleared("abort");
                cmd_valid     = 1'b0;
                mem_rsp_valid = 1'b0;
                return;
            end
            if (done) begin
                ndone++;
                done_t = t;
                chk("done_vs_cmd_ready", 64'(cmd_ready), 64'd0);
            end
            if (prev_qstall) begin
                chk("req_hold_valid", 64'(mem_req_valid), 64'd1);
                chk("req_hold_addr", mem_req_addr, prev_qaddr);
            end
            if (mem_req_valid && mem_req_ready) begin
                chk("req_addr", mem_req_addr, addr + 64'(nreq * P));
                rq.push_back('{t + 1 + dly, addr + 64'(nreq * P)});
                nreq++;
            end
            prev_qstall = mem_req_valid && !mem_req_ready;
            prev_qaddr  = mem_req_addr;
            if (prev_ostall) begin
                chk("out_hold_valid", 64'(out_valid), 64'd1);
                chk("out_hold_data", 64'(out_data), 64'(prev_odata));
                chk("out_hold_last", 64'(out_last), 64'(prev_olast));
            end
            if (out_valid) begin
                if (ncol >= k * passes) begin
                    chk("no_extra_col", 64'(out_valid), 64'd0);
                end else begin
                    if (ncol < k) chk("col_avail", 64'(landed * P >= (ncol + 1) * N), 64'd1);
                    if (out_ready) begin
                        pcol = ncol % k;
                        for (int r = 0; r < N; r++) exp_d[r*DW +: DW] = mem_byte(addr + 64'(pcol * N + r));
                        chk("col_data", 64'(out_data), 64'(exp_d));
                        chk("col_last", 64'(out_last), 64'(pcol == k - 1));
                        ncol++;
                    end
                end
            end
            prev_ostall = out_valid && !out_ready;
            prev_odata  = out_data;
            prev_olast  = out_last;
            if (ndone > 0 && t >= done_t + 2) break;
        end

        chk("done_count", 64'(ndone), 64'd1);
        chk("req_count", 64'(nreq), 64'(exp_reqs));
        chk("col_count", 64'(ncol), 64'(k * passes));
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_cmd_ready", 64'(cmd_ready), 64'd1);
        if (k == 0 || passes == 0) chk("empty_done_lat", 64'(done_t >= 1 && done_t <= 2), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random inputs
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmd_valid     = 1'($urandom);
            cmd_addr      = {$urandom, $urandom};
            cmd_len       = LB'($urandom_range(0, 8));
            cmd_passes    = PB'($urandom_range(0, 3));
            mem_req_ready = 1'($urandom);
            mem_rsp_valid = 1'($urandom);
            mem_rsp_data  = P*DW'($urandom);
            out_ready     = 1'($urandom);
            #1;
            check_cleared("reset");
        end
        @(negedge clk);
        cmd_valid     = 1'b0;
        mem_rsp_valid = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post_reset_busy", 64'(busy), 64'd0);

        run_tile(64'h100, 3, 2, 0, 0, 0, 0);
        run_tile(64'h100, 3, 2, 0, 1, 0, 0);
        run_tile(64'h200, 4, 1, 3, 0, 1, 0);
        run_tile(64'h300, 0, 2, 0, 0, 0, 0);
        run_tile(64'h300, 3, 0, 0, 0, 0, 0);

        // Reset mid-stream with responses still outstanding
        run_tile(64'h400, 4, 2, 3, 0, 0, 9);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = P*DW'($urandom);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        #1;
        chk("late_rsp_busy", 64'(busy), 64'd0);
        chk("late_rsp_out_valid", 64'(out_valid), 64'd0);
        run_tile(64'h40, 1, 1, 0, 0, 0, 0);

        for (int it = 0; it < 20; it++) begin
            run_tile({$urandom, $urandom}, $urandom_range(1, 12), $urandom_range(1, 3),
                     $urandom_range(0, 3), 2, 2, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
